sp_ram_ctrl: RTL and testbench

- Parametrised single-port synchronous RAM with a request/response handshake, per-byte write strobes and a selectable read latency of 1 or 2 cycles.
- Clears itself to zero after every reset.
- Supersedes the fixed-geometry 2Kx8 SP wrapper.
- Sits between the picotiny bus bridge and on-chip block RAM. Used for data/scratch memories of any width or depth.

---
 rtl/sp_ram_pkg.sv | 24 ++
 rtl/sp_ram_array.sv | 33 +++
 rtl/sp_ram_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_sp_ram_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the sp_ram_ctrl family: FSM states, latency bounds,
// byte-strobe merge and even-parity generation.
package sp_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_IDLE
  } state_e;

  localparam int RL_MIN = 1;
  localparam int RL_MAX = 2;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

  // Even parity: the stored bit makes the 9-bit lane carry an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Pure inferred single-port memory with per-lane write enables and registered read.
// One-cycle read latency, read-first on a simultaneous write; no reset, no backpressure.
module sp_ram_array #(
  parameter int W     = 32,
  parameter int NB    = 4,
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          ce_i,
  input  logic          we_i,
  input  logic [NB-1:0] wbe_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o
);

  localparam int LW = W / NB;

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (we_i) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe_i[i]) mem_q[addr_i][i*LW +: LW] <= din_i[i*LW +: LW];
        end
      end
      dout_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-port RAM controller: zero-fills the array after reset, then serves one access per cycle.
// Response READ_LAT (1|2) cycles after accept, no response backpressure; SP_RAM_PARITY_EN adds per-byte parity.
module sp_ram_ctrl
  import sp_ram_pkg::*;
#(
  parameter int DW         = 32,
  parameter int DEPTH      = 2048,
  parameter int AW         = $clog2(DEPTH),
  parameter int READ_LAT   = 1,
  parameter int WRITE_MODE = 0
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [DW/8-1:0] req_wstrb_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_oor_o,
`ifdef SP_RAM_PARITY_EN
  output logic [DW/8-1:0] rsp_perr_o,
`endif
  output logic            busy_o
);

  localparam int NB = DW / 8;
`ifdef SP_RAM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  localparam int MW = NB * LW;
  localparam int RL = (READ_LAT < RL_MIN) ? RL_MIN : (READ_LAT > RL_MAX) ? RL_MAX : READ_LAT;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            acc, oor;

  logic            ram_ce, ram_we;
  logic [NB-1:0]   ram_wbe;
  logic [AW-1:0]   ram_addr;
  logic [MW-1:0]   ram_din, ram_dout, wdata_enc;

  logic            s1_vld_q, s1_we_q, s1_oor_q;
  logic [NB-1:0]   s1_strb_q;
  logic [DW-1:0]   s1_wdata_q;

  logic            rsp_fire;
  logic [DW-1:0]   rdata_c, rdata_q;
`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0]   perr_c;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end
      end
      ST_IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign acc = req_valid_i & req_ready_o;
  assign oor = ({1'b0, req_addr_i} >= DEPTH_W);

  // Out-of-range accesses still read (address 0) to keep timing, but never write.
  always_comb begin
    ram_ce   = acc;
    ram_we   = acc & req_we_i & ~oor;
    ram_wbe  = req_wstrb_i;
    ram_addr = oor ? '0 : req_addr_i;
    ram_din  = wdata_enc;
    if (state_q == ST_CLEAR) begin
      ram_ce   = 1'b1;
      ram_we   = 1'b1;
      ram_wbe  = '1;
      ram_addr = clr_addr_q;
      ram_din  = '0;
    end
  end

  sp_ram_array #(
    .W    (MW),
    .NB   (NB),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk_i (clk_i),
    .ce_i  (ram_ce),
    .we_i  (ram_we),
    .wbe_i (ram_wbe),
    .addr_i(ram_addr),
    .din_i (ram_din),
    .dout_o(ram_dout)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      s1_vld_q   <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_strb_q  <= '0;
      s1_wdata_q <= '0;
    end else begin
      s1_vld_q <= acc;
      if (acc) begin
        s1_we_q    <= req_we_i;
        s1_oor_q   <= oor;
        s1_strb_q  <= req_wstrb_i;
        s1_wdata_q <= req_wdata_i;
      end
    end
  end

  // Writes merge onto the old word read out at the accept edge.
  for (genvar g = 0; g < NB; g++) begin : g_byte
    logic [7:0] old_b;
    assign old_b = ram_dout[g*LW +: 8];
    assign rdata_c[g*8 +: 8] = s1_oor_q ? 8'h00 :
                               s1_we_q  ? byte_merge(old_b, s1_wdata_q[g*8 +: 8], s1_strb_q[g]) :
                                          old_b;
`ifdef SP_RAM_PARITY_EN
    assign wdata_enc[g*LW +: LW] = {byte_parity(req_wdata_i[g*8 +: 8]), req_wdata_i[g*8 +: 8]};
    assign perr_c[g] = ~s1_oor_q & ~(s1_we_q & s1_strb_q[g]) &
                       (byte_parity(old_b) ^ ram_dout[g*LW + 8]);
`else
    assign wdata_enc[g*LW +: LW] = req_wdata_i[g*8 +: 8];
`endif
  end

  assign rsp_fire = s1_vld_q & (~s1_we_q | (WRITE_MODE != 0));

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)     rdata_q <= '0;
    else if (rsp_fire) rdata_q <= rdata_c;
  end

  if (RL == RL_MIN) begin : g_rl1
    assign rsp_valid_o = rsp_fire;
    assign rsp_rdata_o = rsp_fire ? rdata_c : rdata_q;
    assign rsp_oor_o   = rsp_fire & s1_oor_q;
`ifdef SP_RAM_PARITY_EN
    assign rsp_perr_o  = rsp_fire ? perr_c : '0;
`endif
  end else begin : g_rl2
    logic vld_q, oor_q;
`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] perr_q;
`endif
    always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
        vld_q  <= 1'b0;
        oor_q  <= 1'b0;
`ifdef SP_RAM_PARITY_EN
        perr_q <= '0;
`endif
      end else begin
        vld_q <= rsp_fire;
        if (rsp_fire) begin
          oor_q  <= s1_oor_q;
`ifdef SP_RAM_PARITY_EN
          perr_q <= perr_c;
`endif
        end
      end
    end
    assign rsp_valid_o = vld_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_oor_o   = vld_q & oor_q;
`ifdef SP_RAM_PARITY_EN
    assign rsp_perr_o  = vld_q ? perr_q : '0;
`endif
  end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: A = 16 words RL1, B = 12 words RL1 write-through, C = 16 words RL2.
// All three share clock, reset and request inputs; outputs are compared per instance.
module tb_sp_ram_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_we;
  logic [3:0]  req_wstrb, req_addr;
  logic [31:0] req_wdata;

  logic        a_rdy, a_vld, a_oor, a_busy;
  logic        b_rdy, b_vld, b_oor, b_busy;
  logic        c_rdy, c_vld, c_oor, c_busy;
  logic [31:0] a_rd, b_rd, c_rd;
`ifdef SP_RAM_PARITY_EN
  logic [3:0]  a_perr, b_perr, c_perr;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sp_ram_ctrl #(.DW(32), .DEPTH(16), .READ_LAT(1), .WRITE_MODE(0)) u_a (
    .clk_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(a_rdy),
    .req_we_i(req_we), .req_wstrb_i(req_wstrb), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(a_vld), .rsp_rdata_o(a_rd), .rsp_oor_o(a_oor),
`ifdef SP_RAM_PARITY_EN
    .rsp_perr_o(a_perr),
`endif
    .busy_o(a_busy));

  sp_ram_ctrl #(.DW(32), .DEPTH(12), .READ_LAT(1), .WRITE_MODE(1)) u_b (
    .clk_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(b_rdy),
    .req_we_i(req_we), .req_wstrb_i(req_wstrb), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(b_vld), .rsp_rdata_o(b_rd), .rsp_oor_o(b_oor),
`ifdef SP_RAM_PARITY_EN
    .rsp_perr_o(b_perr),
`endif
    .busy_o(b_busy));

  sp_ram_ctrl #(.DW(32), .DEPTH(16), .READ_LAT(2), .WRITE_MODE(0)) u_c (
    .clk_i(clk), .resetn_i(resetn), .req_valid_i(req_valid), .req_ready_o(c_rdy),
    .req_we_i(req_we), .req_wstrb_i(req_wstrb), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(c_vld), .rsp_rdata_o(c_rd), .rsp_oor_o(c_oor),
`ifdef SP_RAM_PARITY_EN
    .rsp_perr_o(c_perr),
`endif
    .busy_o(c_busy));

  typedef struct {
    logic        we;
    logic [3:0]  strb;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] strb, input logic [3:0] addr,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_wstrb = strb;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_wstrb = 4'h0;
  endtask

  // Called at a negedge right after resetn rises; returns busy-cycle counts per instance.
  task automatic clear_len(output int ca, output int cb, output int cc);
    ca = 0; cb = 0; cc = 0;
    for (int k = 0; k < 100 && (a_busy || b_busy || c_busy); k++) begin
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (c_busy) cc++;
      @(negedge clk);
    end
  endtask

  initial begin
    int ca, cb, cc;

    vt[0] = '{1'b1, 4'hF, 4'd5,  32'hAABBCCDD, 32'h0};
    vt[1] = '{1'b1, 4'h5, 4'd5,  32'h11223344, 32'h0};
    vt[2] = '{1'b0, 4'h0, 4'd5,  32'h0,        32'hAA22CC44};
    vt[3] = '{1'b0, 4'h0, 4'd0,  32'h0,        32'h00000000};
    vt[4] = '{1'b1, 4'hF, 4'd15, 32'hCAFEF00D, 32'h0};
    vt[5] = '{1'b1, 4'h0, 4'd15, 32'hFFFFFFFF, 32'h0};
    vt[6] = '{1'b0, 4'h0, 4'd15, 32'h0,        32'hCAFEF00D};
    vt[7] = '{1'b1, 4'hA, 4'd9,  32'h12345678, 32'h0};
    vt[8] = '{1'b0, 4'h0, 4'd9,  32'h0,        32'h12005600};
    vt[9] = '{1'b0, 4'h0, 4'd14, 32'h0,        32'h00000000};

    resetn = 1'b0;
    idle();
    req_addr  = 4'd0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst A busy", a_busy, 1);
    chk("rst A ready", a_rdy, 0);
    chk("rst A valid", a_vld, 0);
    chk("rst A rdata", a_rd, 0);
    chk("rst A oor", a_oor, 0);
    chk("rst C valid", c_vld, 0);
    chk("rst C rdata", c_rd, 0);

    resetn = 1'b1;
    clear_len(ca, cb, cc);
    chk("clear A cycles", ca, 16);
    chk("clear B cycles", cb, 12);
    chk("clear C cycles", cc, 16);
    chk("clear A ready", a_rdy, 1);
    chk("clear B ready", b_rdy, 1);
    chk("clear C ready", c_rdy, 1);

    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk($sformatf("clr rd%0d A valid", i - 1), a_vld, 1);
        chk($sformatf("clr rd%0d A data", i - 1), a_rd, 0);
        chk($sformatf("clr rd%0d A oor", i - 1), a_oor, 0);
        chk($sformatf("clr rd%0d B oor", i - 1), b_oor, (i - 1) >= 12);
`ifdef SP_RAM_PARITY_EN
        chk($sformatf("clr rd%0d A perr", i - 1), a_perr, 0);
`endif
      end
      if (i < 16) drive(1'b0, 4'h0, 4'(i), 32'h0);
      else        idle();
      @(negedge clk);
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vt[i].we, vt[i].strb, vt[i].addr, vt[i].wdata);
      @(negedge clk);
      idle();
      chk($sformatf("vec%0d A valid", i), a_vld, !vt[i].we);
      if (!vt[i].we) chk($sformatf("vec%0d A data", i), a_rd, vt[i].exp);
      chk($sformatf("vec%0d C early", i), c_vld, 0);
      @(negedge clk);
      chk($sformatf("vec%0d C valid", i), c_vld, !vt[i].we);
      if (!vt[i].we) chk($sformatf("vec%0d C data", i), c_rd, vt[i].exp);
      chk($sformatf("vec%0d A pulse", i), a_vld, 0);
    end

    // Write then read-after-write: RL1 answers at T+2, RL2 at T+3.
    @(negedge clk); drive(1'b1, 4'hF, 4'd3, 32'h12345678);
    @(negedge clk); drive(1'b0, 4'h0, 4'd3, 32'h0);
    chk("lat T+1 A valid", a_vld, 0);
    chk("lat T+1 C valid", c_vld, 0);
    @(negedge clk); idle();
    chk("lat T+2 A valid", a_vld, 1);
    chk("lat T+2 A data", a_rd, 32'h12345678);
    chk("lat T+2 C valid", c_vld, 0);
    @(negedge clk);
    chk("lat T+3 C valid", c_vld, 1);
    chk("lat T+3 C data", c_rd, 32'h12345678);
    chk("lat T+3 A valid", a_vld, 0);
    @(negedge clk);
    chk("lat T+4 C valid", c_vld, 0);
    chk("lat T+4 C hold", c_rd, 32'h12345678);

    // Write-through on B.
    @(negedge clk); drive(1'b1, 4'hF, 4'd7, 32'hFFFFFFFF);
    @(negedge clk); drive(1'b1, 4'h3, 4'd7, 32'h00000000);
    chk("wt1 B valid", b_vld, 1);
    chk("wt1 B data", b_rd, 32'hFFFFFFFF);
    @(negedge clk); idle();
    chk("wt2 B valid", b_vld, 1);
    chk("wt2 B data", b_rd, 32'hFFFF0000);
    chk("wt2 A valid", a_vld, 0);
    @(negedge clk);
    chk("wt B pulse", b_vld, 0);
    chk("wt B hold", b_rd, 32'hFFFF0000);

    // Address 13 is out of range only for B.
    @(negedge clk); drive(1'b1, 4'hF, 4'd13, 32'hDEADBEEF);
    @(negedge clk); drive(1'b0, 4'h0, 4'd13, 32'h0);
    chk("oor wr B valid", b_vld, 1);
    chk("oor wr B data", b_rd, 0);
    chk("oor wr B oor", b_oor, 1);
    @(negedge clk); drive(1'b0, 4'h0, 4'd1, 32'h0);
    chk("oor rd B valid", b_vld, 1);
    chk("oor rd B data", b_rd, 0);
    chk("oor rd B oor", b_oor, 1);
    chk("inr rd13 A data", a_rd, 32'hDEADBEEF);
    chk("inr rd13 A oor", a_oor, 0);
    @(negedge clk); idle();
    chk("rd1 B valid", b_vld, 1);
    chk("rd1 B data", b_rd, 0);
    chk("rd1 B oor", b_oor, 0);

    // Reset with a response in flight, then a reset during CLEAR.
    @(negedge clk); drive(1'b1, 4'hF, 4'd2, 32'h5A5A5A5A);
    @(negedge clk); drive(1'b0, 4'h0, 4'd2, 32'h0);
    @(negedge clk); idle();
    chk("pre-rst A data", a_rd, 32'h5A5A5A5A);
    #2 resetn = 1'b0;
    #1;
    chk("mid-rst A valid", a_vld, 0);
    chk("mid-rst A rdata", a_rd, 0);
    chk("mid-rst A busy", a_busy, 1);
    chk("mid-rst A ready", a_rdy, 0);
    @(negedge clk);
    chk("mid-rst C valid", c_vld, 0);
    chk("mid-rst C rdata", c_rd, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("clr5 A busy", a_busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    // Requests held during CLEAR must be ignored.
    drive(1'b1, 4'hF, 4'd2, 32'hFFFFFFFF);
    resetn = 1'b1;
    clear_len(ca, cb, cc);
    idle();
    chk("reclear A cycles", ca, 16);
    chk("reclear C cycles", cc, 16);
    @(negedge clk); drive(1'b0, 4'h0, 4'd2, 32'h0);
    @(negedge clk); idle();
    chk("post A valid", a_vld, 1);
    chk("post A data", a_rd, 0);
    @(negedge clk);
    chk("post C valid", c_vld, 1);
    chk("post C data", c_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
